// File: rtl/pipelined_cla_addsub_64_if.sv
`default_nettype none
// ============================================================================
//  Interface : pipelined_cla_addsub_64_if
//  Purpose   : Operand/result bus of the pipelined 64-bit add/subtract unit.
//              The operand side uses in_valid/in_ready and the result side
//              uses out_valid/out_ready.
//  Modports  : master - drives operands and out_ready, observes results
//              slave  - the arithmetic unit itself
//  Signals   : in_valid, in_ready, a[63:0], b[63:0], cin, sub,
//              out_valid, out_ready, sum[63:0], cout, ovf
//  Revision  : 1.0 - initial release
// ============================================================================
interface pipelined_cla_addsub_64_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_cla_addsub_64.sv
`default_nettype none
// ============================================================================
//  Module    : pipelined_cla_addsub_64
//  Purpose   : 64-bit add/subtract unit made of four 16-bit carry lookahead
//              slices, one slice per pipeline stage. The carry/borrow passes
//              between stages in registers; upper operand slices travel down
//              a skew chain and finished lower result slices down a de-skew
//              chain. One operation per cycle, results in order, latency 4.
//  Ports     : clk  - clock, rising edge
//              rst  - asynchronous active-high reset
//              bus  - slave modport: in_valid/in_ready, a, b, cin, sub,
//                     out_valid/out_ready, sum, cout, ovf
//  Revision  : 1.0 - initial release
// ============================================================================
module pipelined_cla_addsub_64 #(
    parameter int STAGES  = 4,
    parameter int SLICE_W = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    pipelined_cla_addsub_64_if.slave bus
);

    localparam int W = STAGES * SLICE_W;

    // 16-bit CLA slice: four 4-bit groups with group generate/propagate and
    // a lookahead carry across the groups. Returns {carry_out, sum}.
    function automatic logic [SLICE_W:0] cla_slice(
        input logic [SLICE_W-1:0] x,
        input logic [SLICE_W-1:0] y,
        input logic               ci
    );
        logic [SLICE_W-1:0]   g;
        logic [SLICE_W-1:0]   p;
        logic [SLICE_W/4-1:0] gg;
        logic [SLICE_W/4-1:0] gp;
        logic [SLICE_W/4:0]   gc;
        logic [SLICE_W:0]     c;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < SLICE_W/4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        gc[0] = ci;
        gc[1] = gg[0] | (gp[0] & ci);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & ci);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]) | (&gp & ci);
        c = '0;
        for (int j = 0; j < SLICE_W/4; j++) begin
            c[4*j] = gc[j];
            for (int i = 0; i < 3; i++) begin
                c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
            end
        end
        c[SLICE_W] = gc[SLICE_W/4];
        return {c[SLICE_W], p ^ c[SLICE_W-1:0]};
    endfunction

    // ------------------------------------------------------------------
    // Handshake: the whole pipe shifts whenever the output slot is free
    // or being drained, so capacity is exactly one op per stage.
    // ------------------------------------------------------------------
    logic advance;
    logic accept;
    logic out_valid_q;

    assign advance      = ~out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & advance;
    assign bus.in_ready = advance;

    // ------------------------------------------------------------------
    // Stage registers. sN_a_q/sN_b_q hold the slices not yet added (skew
    // chain), sN_res_q the finished low slices (de-skew chain), sN_c_q the
    // carry into the next slice.
    // ------------------------------------------------------------------
    logic                     s0_valid_q, s0_sub_q, s0_c_q;
    logic [SLICE_W-1:0]       s0_res_q;
    logic [W-SLICE_W-1:0]     s0_a_q, s0_b_q;

    logic                     s1_valid_q, s1_sub_q, s1_c_q;
    logic [2*SLICE_W-1:0]     s1_res_q;
    logic [W-2*SLICE_W-1:0]   s1_a_q, s1_b_q;

    logic                     s2_valid_q, s2_sub_q, s2_c_q;
    logic [3*SLICE_W-1:0]     s2_res_q;
    logic [W-3*SLICE_W-1:0]   s2_a_q, s2_b_q;

    logic [W-1:0]             sum_q;
    logic                     cout_q, ovf_q;

    // Subtraction is a + ~b + ~borrow_in; the operand inversion happens
    // once at entry so every slice is a plain adder.
    logic [W-1:0]   bi_d;
    logic           c0_d;
    logic [SLICE_W:0] s0_cla_d, s1_cla_d, s2_cla_d, s3_cla_d;
    logic           c63_d;

    assign bi_d     = bus.sub ? ~bus.b : bus.b;
    assign c0_d     = bus.sub ^ bus.cin;
    assign s0_cla_d = cla_slice(bus.a[SLICE_W-1:0], bi_d[SLICE_W-1:0], c0_d);
    assign s1_cla_d = cla_slice(s0_a_q[SLICE_W-1:0], s0_b_q[SLICE_W-1:0], s0_c_q);
    assign s2_cla_d = cla_slice(s1_a_q[SLICE_W-1:0], s1_b_q[SLICE_W-1:0], s1_c_q);
    assign s3_cla_d = cla_slice(s2_a_q, s2_b_q, s2_c_q);

    // Carry into bit 63 recovered from the top sum bit: s = a ^ b ^ c.
    assign c63_d = s3_cla_d[SLICE_W-1] ^ s2_a_q[SLICE_W-1] ^ s2_b_q[SLICE_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_q  <= 1'b0;
            s0_sub_q    <= 1'b0;
            s0_c_q      <= 1'b0;
            s0_res_q    <= '0;
            s0_a_q      <= '0;
            s0_b_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_sub_q    <= 1'b0;
            s1_c_q      <= 1'b0;
            s1_res_q    <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_sub_q    <= 1'b0;
            s2_c_q      <= 1'b0;
            s2_res_q    <= '0;
            s2_a_q      <= '0;
            s2_b_q      <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            // Valid bits always shift so bubbles move with the data; the
            // payload only loads behind a valid op to avoid needless toggling.
            s0_valid_q  <= accept;
            s1_valid_q  <= s0_valid_q;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;

            if (accept) begin
                s0_sub_q <= bus.sub;
                s0_c_q   <= s0_cla_d[SLICE_W];
                s0_res_q <= s0_cla_d[SLICE_W-1:0];
                s0_a_q   <= bus.a[W-1:SLICE_W];
                s0_b_q   <= bi_d[W-1:SLICE_W];
            end
            if (s0_valid_q) begin
                s1_sub_q <= s0_sub_q;
                s1_c_q   <= s1_cla_d[SLICE_W];
                s1_res_q <= {s1_cla_d[SLICE_W-1:0], s0_res_q};
                s1_a_q   <= s0_a_q[W-SLICE_W-1:SLICE_W];
                s1_b_q   <= s0_b_q[W-SLICE_W-1:SLICE_W];
            end
            if (s1_valid_q) begin
                s2_sub_q <= s1_sub_q;
                s2_c_q   <= s2_cla_d[SLICE_W];
                s2_res_q <= {s2_cla_d[SLICE_W-1:0], s1_res_q};
                s2_a_q   <= s1_a_q[W-2*SLICE_W-1:SLICE_W];
                s2_b_q   <= s1_b_q[W-2*SLICE_W-1:SLICE_W];
            end
            if (s2_valid_q) begin
                sum_q  <= {s3_cla_d[SLICE_W-1:0], s2_res_q};
                cout_q <= s2_sub_q ^ s3_cla_d[SLICE_W];
                ovf_q  <= s3_cla_d[SLICE_W] ^ c63_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_addsub_64.sv
`default_nettype none
// ============================================================================
//  Module    : tb_pipelined_cla_addsub_64
//  Purpose   : Scoreboard bench for pipelined_cla_addsub_64. The driver
//              pushes hand-computed expected results when an operation is
//              accepted; a monitor pops and compares on every retired result.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_pipelined_cla_addsub_64;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        bit          lat;
        int          cyc;
    } exp_t;

    exp_t sbq[$];

    pipelined_cla_addsub_64_if u_if();

    pipelined_cla_addsub_64 #(
        .STAGES (4),
        .SLICE_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Starts at posedge+1, returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [63:0] av, input logic [63:0] bv,
                         input logic ci, input logic sb,
                         input logic [63:0] es, input logic ec, input logic eo,
                         input bit lat, output int acc);
        int   n;
        exp_t e;
        n   = 0;
        acc = -1;
        u_if.in_valid = 1'b1;
        u_if.a        = av;
        u_if.b        = bv;
        u_if.cin      = ci;
        u_if.sub      = sb;
        @(negedge clk);
        while (!u_if.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (u_if.in_ready) begin
            e.sum  = es;
            e.cout = ec;
            e.ovf  = eo;
            e.lat  = lat;
            e.cyc  = cyc;
            sbq.push_back(e);
            acc = cyc;
        end else begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready=0, required 1");
        end
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_outstanding", 66'(sbq.size()), 66'(0));
    endtask

    // Monitor: a result transfers at the next posedge when valid & ready.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && u_if.out_valid && u_if.out_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got sum=%h, required no result", u_if.sum);
            end else begin
                e = sbq.pop_front();
                chk("result{sum,cout,ovf}", {u_if.sum, u_if.cout, u_if.ovf}, {e.sum, e.cout, e.ovf});
                if (e.lat) chk("latency", 66'(cyc - e.cyc), 66'(4));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int acc5;
        int rel;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        u_if.in_valid  = 1'b0;
        u_if.a         = '0;
        u_if.b         = '0;
        u_if.cin       = 1'b0;
        u_if.sub       = 1'b0;
        u_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_out_valid", 66'(u_if.out_valid), 66'(0));
        chk("reset_in_ready",  66'(u_if.in_ready),  66'(1));
        chk("reset_sum",       66'(u_if.sum),       66'(0));
        chk("reset_cout",      66'(u_if.cout),      66'(0));
        chk("reset_ovf",       66'(u_if.ovf),       66'(0));

        // Carry ripples through three slice boundaries.
        issue(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b1, d);
        wait_drain();

        // Full wrap and signed overflow.
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, d);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, d);
        wait_drain();

        // Subtraction and borrow.
        issue(64'h10, 64'h1, 1'b0, 1'b1, 64'hF, 1'b0, 1'b0, 1'b1, d);
        issue(64'h0,  64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, d);
        issue(64'h0,  64'h0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, d);
        wait_drain();

        // Back-to-back alternating add/sub stream.
        issue(64'h1, 64'h2, 1'b0, 1'b0, 64'h3, 1'b0, 1'b0, 1'b1, d);
        issue(64'h64, 64'h14, 1'b0, 1'b1, 64'h50, 1'b0, 1'b0, 1'b1, d);
        issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, d);
        issue(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, d);
        issue(64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0000, 1'b1, 1'b0, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 1'b1, d);
        issue(64'h5, 64'h5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, d);
        issue(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0, 1'b1, d);
        issue(64'h0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1, d);
        wait_drain();

        // Backpressure: four fill the pipe, the fifth waits for a retire.
        u_if.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            issue(64'(i), 64'(i), 1'b0, 1'b0, 64'(2*i), 1'b0, 1'b0, 1'b0, d);
        end
        rel = -2;
        fork
            issue(64'd5, 64'd5, 1'b0, 1'b0, 64'd10, 1'b0, 1'b0, 1'b1, acc5);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready",  66'(u_if.in_ready),  66'(0));
                    chk("bp_out_valid", 66'(u_if.out_valid), 66'(1));
                    chk("bp_held_sum",  66'(u_if.sum),       66'(2));
                end
                @(posedge clk);
                #1;
                u_if.out_ready = 1'b1;
                rel = cyc;
            end
        join
        chk("bp_op5_accept_cycle", 66'(acc5), 66'(rel));
        wait_drain();

        // Reset while three operations are in flight.
        u_if.out_ready = 1'b0;
        issue(64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 1'b0, 1'b0, 1'b0, d);
        issue(64'h2, 64'h2, 1'b0, 1'b0, 64'h4, 1'b0, 1'b0, 1'b0, d);
        issue(64'h3, 64'h3, 1'b0, 1'b0, 64'h6, 1'b0, 1'b0, 1'b0, d);
        @(posedge clk);
        #1;
        chk("pre_reset_out_valid", 66'(u_if.out_valid), 66'(1));
        #1;
        rst = 1'b1;
        sbq.delete();
        #1;
        chk("async_reset_out_valid", 66'(u_if.out_valid), 66'(0));
        chk("async_reset_in_ready",  66'(u_if.in_ready),  66'(1));
        chk("async_reset_sum",       66'(u_if.sum),       66'(0));
        #1;
        rst = 1'b0;
        u_if.out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_reset_no_stale", 66'(u_if.out_valid), 66'(0));
        issue(64'h5, 64'h3, 1'b0, 1'b1, 64'h2, 1'b0, 1'b0, 1'b1, d);
        wait_drain();

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
